// File: rtl/scratchpad_pkg.sv
// -----------------------------------------------------------------------------
// scratchpad_pkg
// Shared definitions for the banked index-register scratchpad:
//   - state_t   : access-sequencer states (IDLE, PRE, RD, MOD, WB)
//   - op_t      : request operation codes carried on req_op
//   - clog2_min1: address-width helper that never returns 0
// -----------------------------------------------------------------------------
package scratchpad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_RD,
        ST_MOD,
        ST_WB
    } state_t;

    // Bit 0 set means the operation writes; bit 1 set means it covers a whole pair.
    typedef enum logic [1:0] {
        OP_RD_REG  = 2'b00,
        OP_WR_REG  = 2'b01,
        OP_RD_PAIR = 2'b10,
        OP_WR_PAIR = 2'b11
    } op_t;

    // Width of a select field for n choices; a single choice still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scratchpad_banked_if.sv
// -----------------------------------------------------------------------------
// scratchpad_banked_if
// Request/response bus of the banked scratchpad.
//   req_valid/req_ready : single-cycle handshake, accepted when both high
//   req_op/bank/idx/wdata: request payload (see scratchpad_pkg::op_t)
//   rsp_valid           : one-cycle read-data pulse, no backpressure
//   rsp_data            : read data, held between pulses
// Modports: master (CPU core side), slave (scratchpad side).
// -----------------------------------------------------------------------------
interface scratchpad_banked_if #(
    parameter int DW = 4,
    parameter int IW = 4,
    parameter int BW = 1
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [BW-1:0]     req_bank;
    logic [IW-1:0]     req_idx;
    logic [2*DW-1:0]   req_wdata;
    logic              rsp_valid;
    logic [2*DW-1:0]   rsp_data;

    modport master (
        output req_valid, req_op, req_bank, req_idx, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_bank, req_idx, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/scratchpad_rfsh.sv
// -----------------------------------------------------------------------------
// scratchpad_rfsh
// Refresh scheduler: a free-running timer that raises a refresh request every
// RFSH_PERIOD cycles, plus the pointer to the next row to refresh.
//   i_sysclk, i_poc   : clock, asynchronous active-high clear
//   i_rfsh_take       : sequencer has started the pending refresh
//   i_rfsh_done       : refresh write-back finished, advance the row pointer
//   o_rfsh_pending    : a refresh is waiting for the sequencer
//   o_rfsh_row        : row the next refresh targets
// -----------------------------------------------------------------------------
module scratchpad_rfsh
    import scratchpad_pkg::*;
#(
    parameter int RFSH_PERIOD = 64,
    parameter int ROWS        = 16,
    parameter int RW          = 4
) (
    input  logic          i_sysclk,
    input  logic          i_poc,
    input  logic          i_rfsh_take,
    input  logic          i_rfsh_done,
    output logic          o_rfsh_pending,
    output logic [RW-1:0] o_rfsh_row
);
    localparam int TW = clog2_min1(RFSH_PERIOD);

    logic [TW-1:0] r_timer;
    logic          r_pending;
    logic [RW-1:0] r_row;

    always_ff @(posedge i_sysclk or posedge i_poc) begin
        if (i_poc) begin
            r_timer   <= '0;
            r_pending <= 1'b0;
            r_row     <= '0;
        end else begin
            // A wrap sets the request even if the previous one is taken on
            // the same edge, so no refresh slot is ever lost.
            if (r_timer == TW'(RFSH_PERIOD - 1)) begin
                r_timer   <= '0;
                r_pending <= 1'b1;
            end else begin
                r_timer <= r_timer + TW'(1);
                if (i_rfsh_take) r_pending <= 1'b0;
            end

            if (i_rfsh_done)
                r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
        end
    end

    assign o_rfsh_pending = r_pending;
    assign o_rfsh_row     = r_row;
endmodule

// File: rtl/scratchpad_banked.sv
// -----------------------------------------------------------------------------
// scratchpad_banked
// Multi-bank index-register scratchpad modelled as a row-buffered array.
// Every access (and every autonomous refresh) runs PRE -> RD -> MOD -> WB
// through a single row buffer, giving one access per 5 cycles.
//   i_sysclk    : sole clock
//   i_poc       : power-on clear, asynchronous active-high; aborts any sequence
//   bus         : scratchpad_banked_if slave (request handshake + response)
//   o_rfsh_busy : high from PRE through WB of a refresh sequence
// Out-of-range banks are sequenced normally but never written and read as 0.
// -----------------------------------------------------------------------------
module scratchpad_banked
    import scratchpad_pkg::*;
#(
    parameter int DW          = 4,
    parameter int PAIRS       = 8,
    parameter int BANKS       = 2,
    parameter int RFSH_PERIOD = 64,
    parameter int BW          = clog2_min1(BANKS)
) (
    input  logic                i_sysclk,
    input  logic                i_poc,
    scratchpad_banked_if.slave  bus,
    output logic                o_rfsh_busy
);
    localparam int IW   = $clog2(2 * PAIRS);
    localparam int RW   = $clog2(BANKS * PAIRS);
    localparam int ROWS = BANKS * PAIRS;

    state_t          r_state, w_state_nxt;
    op_t             r_op;
    logic [RW-1:0]   r_row;
    logic            r_half;
    logic            r_bad;
    logic            r_is_rfsh;
    logic [2*DW-1:0] r_wdata;
    logic [2*DW-1:0] r_rbuf;
    logic            r_rsp_valid;
    logic [2*DW-1:0] r_rsp_data;
    logic [2*DW-1:0] r_mem [ROWS];

    logic            w_accept;
    logic            w_rfsh_take;
    logic            w_rfsh_done;
    logic            w_rfsh_pending;
    logic [RW-1:0]   w_rfsh_row;
    logic [RW-1:0]   w_req_row;
    logic            w_req_bad;

    // Row = bank * PAIRS + idx row; computed wide, then truncated so a bad
    // bank cannot widen the pointer (its access is masked by r_bad anyway).
    assign w_req_row = RW'(int'(bus.req_bank) * PAIRS + int'(bus.req_idx[IW-1:1]));
    assign w_req_bad = int'(bus.req_bank) >= BANKS;

    scratchpad_rfsh #(
        .RFSH_PERIOD (RFSH_PERIOD),
        .ROWS        (ROWS),
        .RW          (RW)
    ) u_rfsh (
        .i_sysclk       (i_sysclk),
        .i_poc          (i_poc),
        .i_rfsh_take    (w_rfsh_take),
        .i_rfsh_done    (w_rfsh_done),
        .o_rfsh_pending (w_rfsh_pending),
        .o_rfsh_row     (w_rfsh_row)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_sysclk or posedge i_poc) begin
        if (i_poc) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every output of this block is given a default first so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_rfsh_take = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rfsh_pending) begin
                    w_rfsh_take = 1'b1;
                    w_state_nxt = ST_PRE;
                end else if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_PRE;
                end
            end
            ST_PRE:  w_state_nxt = ST_RD;
            ST_RD:   w_state_nxt = ST_MOD;
            ST_MOD:  w_state_nxt = ST_WB;
            ST_WB:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready = (r_state == ST_IDLE) && !w_rfsh_pending;
    assign w_rfsh_done   = (r_state == ST_WB) && r_is_rfsh;
    assign o_rfsh_busy   = (r_state != ST_IDLE) && r_is_rfsh;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

    // Sequencer datapath: latch the request, then walk the row buffer.
    always_ff @(posedge i_sysclk or posedge i_poc) begin
        if (i_poc) begin
            r_op        <= OP_RD_REG;
            r_row       <= '0;
            r_half      <= 1'b0;
            r_bad       <= 1'b0;
            r_is_rfsh   <= 1'b0;
            r_wdata     <= '0;
            r_rbuf      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rfsh_take) begin
                        // A refresh is a read-pair with the response suppressed.
                        r_op      <= OP_RD_PAIR;
                        r_row     <= w_rfsh_row;
                        r_bad     <= 1'b0;
                        r_is_rfsh <= 1'b1;
                    end else if (w_accept) begin
                        r_op      <= op_t'(bus.req_op);
                        r_row     <= w_req_row;
                        r_half    <= bus.req_idx[0];
                        r_wdata   <= bus.req_wdata;
                        r_bad     <= w_req_bad;
                        r_is_rfsh <= 1'b0;
                    end
                end
                ST_PRE: r_rbuf <= '0;
                ST_RD:  r_rbuf <= r_bad ? '0 : r_mem[r_row];
                ST_MOD: begin
                    case (r_op)
                        OP_WR_REG: begin
                            if (r_half) r_rbuf[2*DW-1:DW] <= r_wdata[DW-1:0];
                            else        r_rbuf[DW-1:0]    <= r_wdata[DW-1:0];
                        end
                        OP_WR_PAIR: r_rbuf <= r_wdata;
                        default: ;
                    endcase
                end
                ST_WB: begin
                    if (!r_is_rfsh && (r_op == OP_RD_REG || r_op == OP_RD_PAIR)) begin
                        r_rsp_valid <= 1'b1;
                        if (r_op == OP_RD_PAIR)
                            r_rsp_data <= r_rbuf;
                        else
                            r_rsp_data <= {{DW{1'b0}}, (r_half ? r_rbuf[2*DW-1:DW] : r_rbuf[DW-1:0])};
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array is ordinary flops because power-on clear must zero
    // every row asynchronously; a resettable memory cannot map to RAM.
    always_ff @(posedge i_sysclk or posedge i_poc) begin
        if (i_poc) begin
            for (int i = 0; i < ROWS; i++) r_mem[i] <= '0;
        end else if (r_state == ST_WB && !r_bad) begin
            r_mem[r_row] <= r_rbuf;
        end
    end
endmodule

// File: tb/tb_scratchpad_banked.sv
module tb_scratchpad_banked;
    localparam int DW    = 4;
    localparam int PAIRS = 8;
    localparam int BANKS = 2;
    localparam int BW    = 2;
    localparam int IW    = 4;
    localparam int P     = 64;

    localparam logic [1:0] RD_REG  = 2'b00;
    localparam logic [1:0] WR_REG  = 2'b01;
    localparam logic [1:0] RD_PAIR = 2'b10;
    localparam logic [1:0] WR_PAIR = 2'b11;

    typedef struct {
        logic [1:0]    op;
        logic [BW-1:0] bank;
        logic [IW-1:0] idx;
        logic [7:0]    wdata;
        logic [7:0]    exp;
    } vec_t;

    logic clk = 1'b0;
    logic poc = 1'b1;
    logic rfsh_busy;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] last_rsp = 8'h00;
    vec_t vecs [16];

    scratchpad_banked_if #(.DW(DW), .IW(IW), .BW(BW)) bus ();

    scratchpad_banked #(
        .DW(DW), .PAIRS(PAIRS), .BANKS(BANKS), .RFSH_PERIOD(P), .BW(BW)
    ) dut (
        .i_sysclk    (clk),
        .i_poc       (poc),
        .bus         (bus),
        .o_rfsh_busy (rfsh_busy)
    );

    always #5 clk = ~clk;

    // Edges since power-on clear released; the refresh timer wraps whenever
    // this reaches a multiple of P.
    always @(posedge clk or posedge poc) begin
        if (poc) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge, then watch 8 cycles after acceptance.
    task automatic do_req(input string name, input logic [1:0] op, input logic [BW-1:0] bank,
                          input logic [IW-1:0] idx, input logic [7:0] wdata, input logic [7:0] exp);
        int n = 0;
        int c0 = 0;
        int lat = -1;
        int pulses = 0;
        logic [7:0] got = 8'h00;
        logic exp_rdy;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_bank  = bank;
        bus.req_idx   = idx;
        bus.req_wdata = wdata;
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check({name, " accept"}, 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) c0 = cyc;
            if (k == 4) begin
                exp_rdy = 1'b1;
                for (int e = c0; e <= c0 + 4; e++) if (e % P == 0) exp_rdy = 1'b0;
                check({name, " ready_after_E4"}, 32'(bus.req_ready), 32'(exp_rdy));
            end
            if (bus.rsp_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    got = bus.rsp_data;
                end
            end
        end
        if (!op[0]) begin
            check({name, " pulses"}, 32'(pulses), 32'd1);
            check({name, " latency"}, 32'(lat), 32'd4);
            check({name, " data"}, 32'(got), 32'(exp));
            last_rsp = exp;
        end else begin
            check({name, " pulses"}, 32'(pulses), 32'd0);
            check({name, " rsp_hold"}, 32'(bus.rsp_data), 32'(last_rsp));
        end
    endtask

    initial begin
        int busy_n;
        int wait_n;
        int mon;

        vecs[0]  = '{WR_REG,  2'd1, 4'd5,  8'h0A, 8'h00};
        vecs[1]  = '{RD_REG,  2'd1, 4'd5,  8'h00, 8'h0A};
        vecs[2]  = '{WR_PAIR, 2'd0, 4'd2,  8'h3C, 8'h00};
        vecs[3]  = '{RD_REG,  2'd0, 4'd2,  8'h00, 8'h0C};
        vecs[4]  = '{RD_REG,  2'd0, 4'd3,  8'h00, 8'h03};
        vecs[5]  = '{RD_PAIR, 2'd1, 4'd2,  8'h00, 8'h00};
        vecs[6]  = '{RD_PAIR, 2'd1, 4'd4,  8'h00, 8'hA0};
        vecs[7]  = '{RD_PAIR, 2'd0, 4'd2,  8'h00, 8'h3C};
        vecs[8]  = '{WR_REG,  2'd0, 4'd3,  8'hE5, 8'h00};
        vecs[9]  = '{RD_PAIR, 2'd0, 4'd3,  8'h00, 8'h5C};
        vecs[10] = '{WR_PAIR, 2'd1, 4'd15, 8'h96, 8'h00};
        vecs[11] = '{RD_REG,  2'd1, 4'd15, 8'h00, 8'h09};
        vecs[12] = '{RD_REG,  2'd1, 4'd14, 8'h00, 8'h06};
        vecs[13] = '{WR_REG,  2'd1, 4'd14, 8'h01, 8'h00};
        vecs[14] = '{RD_PAIR, 2'd1, 4'd14, 8'h00, 8'h91};
        vecs[15] = '{RD_REG,  2'd1, 4'd4,  8'h00, 8'h00};

        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_bank  = '0;
        bus.req_idx   = '0;
        bus.req_wdata = '0;

        // Reset state and cleared array.
        repeat (3) @(negedge clk);
        poc = 1'b0;
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset rfsh_busy", 32'(rfsh_busy), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_data", 32'(bus.rsp_data), 32'd0);
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < PAIRS; r++)
                do_req($sformatf("reset_row b%0d r%0d", b, r), RD_PAIR, BW'(b), IW'(2 * r), 8'h00, 8'h00);

        // Directed vectors.
        for (int i = 0; i < 16; i++)
            do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].bank, vecs[i].idx, vecs[i].wdata, vecs[i].exp);

        // Refresh priority: request raised right after a timer wrap.
        while (cyc % P != 0) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = RD_REG;
        bus.req_bank  = 2'd1;
        bus.req_idx   = 4'd5;
        check("rfsh ready_blocked", 32'(bus.req_ready), 32'd0);
        busy_n = 0;
        wait_n = 0;
        for (int k = 1; k <= 12 && wait_n == 0; k++) begin
            @(negedge clk);
            if (rfsh_busy) busy_n++;
            if (bus.req_ready) wait_n = k;
        end
        check("rfsh busy_cycles", 32'(busy_n), 32'd4);
        check("rfsh accept_delay", 32'(wait_n), 32'd5);
        do_req("rfsh held_req", RD_REG, 2'd1, 4'd5, 8'h00, 8'h0A);

        // Data retention across more than 2*BANKS*PAIRS refreshes.
        repeat ((2 * BANKS * PAIRS + 2) * P) @(negedge clk);
        do_req("retain b1r2", RD_PAIR, 2'd1, 4'd4,  8'h00, 8'hA0);
        do_req("retain b0r1", RD_PAIR, 2'd0, 4'd2,  8'h00, 8'h5C);
        do_req("retain b1r7", RD_PAIR, 2'd1, 4'd14, 8'h00, 8'h91);
        do_req("retain b0r0", RD_PAIR, 2'd0, 4'd0,  8'h00, 8'h00);

        // Out-of-range bank 3 aliases onto bank 1 row 0 if not suppressed.
        do_req("bad prep_wr", WR_PAIR, 2'd1, 4'd0, 8'h77, 8'h00);
        do_req("bad wr",      WR_PAIR, 2'd3, 4'd0, 8'h5A, 8'h00);
        do_req("bad rd_pair", RD_PAIR, 2'd3, 4'd0, 8'h00, 8'h00);
        do_req("bad rd_reg",  RD_REG,  2'd3, 4'd1, 8'h00, 8'h00);
        do_req("bad alias",   RD_PAIR, 2'd1, 4'd0, 8'h00, 8'h77);
        do_req("bad b0r0",    RD_PAIR, 2'd0, 4'd0, 8'h00, 8'h00);

        // Abort: power-on clear while a write pair sits in MOD.
        bus.req_valid = 1'b1;
        bus.req_op    = WR_PAIR;
        bus.req_bank  = 2'd0;
        bus.req_idx   = 4'd6;
        bus.req_wdata = 8'hFF;
        mon = 0;
        while (!bus.req_ready && mon < 40) begin
            @(negedge clk);
            mon++;
        end
        check("abort accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        poc = 1'b1;
        @(negedge clk);
        poc = 1'b0;
        check("abort req_ready", 32'(bus.req_ready), 32'd1);
        check("abort rfsh_busy", 32'(rfsh_busy), 32'd0);
        mon = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) mon++;
        end
        check("abort no_rsp", 32'(mon), 32'd0);
        last_rsp = 8'h00;
        do_req("abort row", RD_PAIR, 2'd0, 4'd6, 8'h00, 8'h00);
        do_req("abort cleared b1r0", RD_PAIR, 2'd1, 4'd0, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
